mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (IFU, LSU) to single-memory-port arbiter.
// One transaction in flight at a time, tracked by an IDLE -> REQ -> RSP FSM.
// Ties between the masters are broken round-robin using the last granted master.
// The request valid and payload towards memory are registered when the grant is taken;
// the ready/valid pass-through signals are combinational on the registered grant.

module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  // Instruction fetch master
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [DATA_W-1:0]     ifu_rdata,

  // Load/store master
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_rsp_valid,
  input  logic                  lsu_rsp_ready,
  output logic [DATA_W-1:0]     lsu_rdata,

  // Memory port
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRsp
  } state_t;

  typedef enum logic [1:0] {
    GntNone,
    GntIfu,
    GntLsu
  } grant_t;

  state_t              state_q;
  grant_t              grant_q;
  // 1 when the LSU was the last master to complete a request handshake
  logic                last_lsu_q;
  logic                mem_req_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_wen_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [MASK_W-1:0]   mem_wmask_q;

  logic                any_req;
  logic                pick_lsu;
  logic                req_hs;
  logic                rsp_hs;

  // Arbitration decision: a lone requester wins, a tie goes to the master not granted last
  always_comb begin
    any_req  = ifu_req_valid | lsu_req_valid;
    pick_lsu = 1'b0;
    if (lsu_req_valid && ifu_req_valid) begin
      pick_lsu = ~last_lsu_q;
    end else if (lsu_req_valid) begin
      pick_lsu = 1'b1;
    end
  end

  // Handshake strobes on the memory side, only meaningful in their own state
  always_comb begin
    req_hs = (state_q == StReq) && mem_req_valid_q && mem_req_ready;
    rsp_hs = (state_q == StRsp) && mem_rsp_valid && mem_rsp_ready;
  end

  // FSM, grant tracking and registered memory request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      grant_q         <= GntNone;
      last_lsu_q      <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q         <= StReq;
            grant_q         <= pick_lsu ? GntLsu : GntIfu;
            mem_req_valid_q <= 1'b1;
            // Masters hold payload while valid, so capturing it here is equivalent to a mux
            if (pick_lsu) begin
              mem_addr_q  <= lsu_addr;
              mem_wen_q   <= lsu_wen;
              mem_wdata_q <= lsu_wdata;
              mem_wmask_q <= lsu_wmask;
            end else begin
              mem_addr_q  <= ifu_addr;
              mem_wen_q   <= 1'b0;
              mem_wdata_q <= '0;
              mem_wmask_q <= '0;
            end
          end
        end

        StReq: begin
          if (req_hs) begin
            state_q         <= StRsp;
            last_lsu_q      <= (grant_q == GntLsu);
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
          end
        end

        StRsp: begin
          if (rsp_hs) begin
            state_q <= StIdle;
            grant_q <= GntNone;
          end
        end

        default: begin
          state_q         <= StIdle;
          grant_q         <= GntNone;
          mem_req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory request outputs; valid is forced low while reset is held
  always_comb begin
    mem_req_valid = mem_req_valid_q & ~rst;
    mem_addr      = mem_addr_q;
    mem_wen       = mem_wen_q;
    mem_wdata     = mem_wdata_q;
    mem_wmask     = mem_wmask_q;
  end

  // Ready/valid routing between the granted master and memory
  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StReq: begin
          if (grant_q == GntIfu) begin
            ifu_req_ready = mem_req_ready;
          end else if (grant_q == GntLsu) begin
            lsu_req_ready = mem_req_ready;
          end
        end
        StRsp: begin
          if (grant_q == GntIfu) begin
            ifu_rsp_valid = mem_rsp_valid;
            mem_rsp_ready = ifu_rsp_ready;
          end else if (grant_q == GntLsu) begin
            lsu_rsp_valid = mem_rsp_valid;
            mem_rsp_ready = lsu_rsp_ready;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read data is broadcast; each master qualifies it with its own rsp_valid
  always_comb begin
    ifu_rdata = mem_rdata;
    lsu_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected memory requests
// and responses; a monitor pops and compares on each handshake.

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rdata     (mem_rdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mreq_t;

  mreq_t       exp_mem[$];
  logic [31:0] exp_ifu[$];
  logic [31:0] exp_lsu[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // memory stub controls
  int   stall_left = 0;
  logic force_rsp  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] stub_rdata(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Memory stub: accepts after stall_left cycles, answers on the cycle after acceptance
  initial begin : mem_stub
    logic        req_hs, rsp_hs, cap_wen, pending;
    logic [31:0] cap_addr, pend_data;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    pending       = 1'b0;
    pend_data     = '0;
    forever begin
      @(negedge clk);
      req_hs   = mem_req_valid && mem_req_ready;
      rsp_hs   = mem_rsp_valid && mem_rsp_ready;
      cap_addr = mem_addr;
      cap_wen  = mem_wen;
      @(posedge clk);
      #1;
      if (rst) begin
        pending       = 1'b0;
        mem_req_ready = 1'b0;
      end else begin
        if (rsp_hs) pending = 1'b0;
        if (req_hs) begin
          pending   = 1'b1;
          pend_data = cap_wen ? 32'h0 : stub_rdata(cap_addr);
        end
        if (mem_req_valid) begin
          if (stall_left > 0) begin
            mem_req_ready = 1'b0;
            stall_left--;
          end else begin
            mem_req_ready = 1'b1;
          end
        end else begin
          mem_req_ready = 1'b0;
        end
      end
      mem_rsp_valid = pending || force_rsp;
      mem_rdata     = pending ? pend_data : (force_rsp ? 32'h1234_5678 : 32'h0);
    end
  end

  // Monitor: scoreboard pops on handshakes plus exclusivity and payload-stability checks
  initial begin : monitor
    logic  prev_wait;
    mreq_t prev_req, cur_req, e;
    prev_wait = 1'b0;
    prev_req  = '0;
    forever begin
      @(negedge clk);
      cur_req = '{addr: mem_addr, wen: mem_wen, wdata: mem_wdata, wmask: mem_wmask};
      if (mem_req_valid && mem_req_ready) begin
        if (exp_mem.size() == 0) begin
          check("mem_req_unexpected_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_mem.pop_front();
          check("mem_req_addr", mem_addr, e.addr);
          check("mem_req_wen_wdata_wmask", {mem_wen, mem_wdata, mem_wmask},
                {e.wen, e.wdata, e.wmask});
        end
      end
      if (ifu_rsp_valid && ifu_rsp_ready) begin
        if (exp_ifu.size() == 0) check("ifu_rsp_unexpected", ifu_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("ifu_rdata", ifu_rdata, exp_ifu.pop_front());
      end
      if (lsu_rsp_valid && lsu_rsp_ready) begin
        if (exp_lsu.size() == 0) check("lsu_rsp_unexpected", lsu_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("lsu_rdata", lsu_rdata, exp_lsu.pop_front());
      end
      if (ifu_rsp_valid) check("lsu_rsp_valid_excl", lsu_rsp_valid, 0);
      if (ifu_req_ready) check("lsu_req_ready_excl", lsu_req_ready, 0);
      if (!rst && prev_wait && mem_req_valid) check("mem_payload_stable", cur_req, prev_req);
      prev_wait = !rst && mem_req_valid && !mem_req_ready;
      prev_req  = cur_req;
    end
  end

  task automatic push_mem(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] m);
    exp_mem.push_back('{addr: a, wen: w, wdata: d, wmask: m});
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge
  task automatic drive_ifu(input logic [31:0] a);
    int n;
    ifu_addr      = a;
    ifu_req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifu_req_ready && n < 40);
    check("ifu_req_accept", ifu_req_ready, 1);
    @(posedge clk);
    #1;
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
  endtask

  task automatic drive_lsu(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] m, output int vcyc, output int rcyc);
    int n;
    lsu_addr      = a;
    lsu_wen       = w;
    lsu_wdata     = d;
    lsu_wmask     = m;
    lsu_req_valid = 1'b1;
    n = 0;
    vcyc = 0;
    rcyc = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_req_valid) vcyc++;
      if (lsu_req_ready) rcyc++;
    end while (!lsu_req_ready && n < 40);
    check("lsu_req_accept", lsu_req_ready, 1);
    @(posedge clk);
    #1;
    lsu_req_valid = 1'b0;
    lsu_addr      = '0;
    lsu_wen       = 1'b0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_mem.size() + exp_ifu.size() + exp_lsu.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_mem.size() + exp_ifu.size() + exp_lsu.size(), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_req_readys", {ifu_req_ready, lsu_req_ready}, 0);
    check("rst_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    check("rst_mem_rsp_ready", mem_rsp_ready, 0);
    check("rst_payload", {mem_addr, mem_wen, mem_wdata, mem_wmask}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : stimulus
    int v0, r0, v1, r1, n;
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = '0; ifu_rsp_ready = 1'b1;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    lsu_rsp_ready = 1'b1;
    do_reset();

    // IFU alone: ready on the second cycle, fetch data returned
    push_mem(32'h8000_0000, 1'b0, 32'h0, 4'h0);
    exp_ifu.push_back(32'h0000_0413);
    ifu_addr      = 32'h8000_0000;
    ifu_req_valid = 1'b1;
    @(negedge clk);
    check("ifu_req_ready_c1", ifu_req_ready, 0);
    check("mem_req_valid_c1", mem_req_valid, 0);
    @(negedge clk);
    check("ifu_req_ready_c2", ifu_req_ready, 1);
    check("lsu_req_ready_c2", lsu_req_ready, 0);
    @(posedge clk);
    #1;
    ifu_req_valid = 1'b0;
    wait_drain();

    // Tie right after reset: LSU first, then IFU
    do_reset();
    push_mem(32'h8000_0200, 1'b0, 32'h0, 4'h0);
    push_mem(32'h8000_0100, 1'b0, 32'h0, 4'h0);
    exp_lsu.push_back(32'hDA5A_585A);
    exp_ifu.push_back(32'hDA5A_5B5A);
    fork
      drive_ifu(32'h8000_0100);
      drive_lsu(32'h8000_0200, 1'b0, 32'h0, 4'h0, v0, r0);
    join
    wait_drain();

    // LSU alone, then a tie: IFU must win since LSU went last
    push_mem(32'h8000_0300, 1'b0, 32'h0, 4'h0);
    exp_lsu.push_back(32'hDA5A_595A);
    drive_lsu(32'h8000_0300, 1'b0, 32'h0, 4'h0, v0, r0);
    wait_drain();
    push_mem(32'h8000_0400, 1'b0, 32'h0, 4'h0);
    push_mem(32'h8000_0500, 1'b0, 32'h0, 4'h0);
    exp_ifu.push_back(32'hDA5A_5E5A);
    exp_lsu.push_back(32'hDA5A_5F5A);
    fork
      drive_ifu(32'h8000_0400);
      drive_lsu(32'h8000_0500, 1'b0, 32'h0, 4'h0, v1, r1);
    join
    wait_drain();

    // Store with memory stalling 3 cycles: 4 valid cycles, one ready cycle
    stall_left = 3;
    push_mem(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    exp_lsu.push_back(32'h0);
    drive_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, v0, r0);
    check("store_valid_cycles", v0, 4);
    check("store_ready_cycles", r0, 1);
    wait_drain();

    // LSU response back-pressured for 2 cycles
    lsu_rsp_ready = 1'b0;
    push_mem(32'h8000_0600, 1'b0, 32'h0, 4'h0);
    exp_lsu.push_back(32'hDA5A_5C5A);
    drive_lsu(32'h8000_0600, 1'b0, 32'h0, 4'h0, v0, r0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lsu_rsp_valid && n < 20);
    check("bp1_lsu_rsp_valid", lsu_rsp_valid, 1);
    check("bp1_mem_rsp_ready", mem_rsp_ready, 0);
    @(negedge clk);
    check("bp2_lsu_rsp_valid", lsu_rsp_valid, 1);
    check("bp2_mem_rsp_ready", mem_rsp_ready, 0);
    @(posedge clk);
    #1;
    lsu_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_mem_rsp_ready", mem_rsp_ready, 1);
    @(negedge clk);
    check("bp_idle_after", {lsu_rsp_valid, mem_rsp_ready, mem_req_valid}, 0);
    @(posedge clk);
    #1;
    wait_drain();

    // Reset while in RSP, with memory still asserting a response
    ifu_rsp_ready = 1'b0;
    push_mem(32'h8000_0700, 1'b0, 32'h0, 4'h0);
    drive_ifu(32'h8000_0700);
    rst       = 1'b1;
    force_rsp = 1'b1;
    @(negedge clk);
    check("rstrsp_ifu_rsp_valid", ifu_rsp_valid, 0);
    check("rstrsp_mem_rsp_ready", mem_rsp_ready, 0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    ifu_rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 0);
      check("post_rst_mem_rsp_ready", mem_rsp_ready, 0);
    end
    @(posedge clk);
    #1;
    force_rsp = 1'b0;
    @(posedge clk);
    #1;
    // Fresh tie after that reset goes to LSU again
    push_mem(32'h8000_0900, 1'b1, 32'h0000_00AA, 4'h1);
    push_mem(32'h8000_0800, 1'b0, 32'h0, 4'h0);
    exp_lsu.push_back(32'h0);
    exp_ifu.push_back(32'hDA5A_525A);
    fork
      drive_ifu(32'h8000_0800);
      drive_lsu(32'h8000_0900, 1'b1, 32'h0000_00AA, 4'h1, v1, r1);
    join
    wait_drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
